seg7_scan_driver: RTL and testbench

//   Parametrised time-multiplexed driver for a DIGITS-wide common-anode 7-segment bank.
//   - Per-digit hex decode, decimal-point and blank controls.
//   - Frame-coherent input snapshot and an anti-ghost blanking gap at each digit switch.
//   - Sits between the datapath's hex word and the board anode/cathode pins; one instance per display bank.

---
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 7-segment bank with frame-coherent snapshot and anti-ghost gap.
// Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan_driver #(
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 500
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic                                          en,
   input  logic [4*DIGITS-1:0]                           value,
   input  logic [DIGITS-1:0]                             dp_in,
   input  logic [DIGITS-1:0]                             blank,
   output logic [DIGITS-1:0]                             anode,
   output logic [7:0]                                    cathode,
   output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
   output logic                                          frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   function automatic logic [6:0] hex_seg(input logic [3:0] nib);
      case (nib)
         4'h0: hex_seg = 7'h01;  4'h1: hex_seg = 7'h4F;
         4'h2: hex_seg = 7'h12;  4'h3: hex_seg = 7'h06;
         4'h4: hex_seg = 7'h4C;  4'h5: hex_seg = 7'h24;
         4'h6: hex_seg = 7'h20;  4'h7: hex_seg = 7'h0F;
         4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h04;
         4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h60;
         4'hC: hex_seg = 7'h31;  4'hD: hex_seg = 7'h42;
         4'hE: hex_seg = 7'h30;  default: hex_seg = 7'h38;
      endcase
   endfunction

   logic [SC_W-1:0]     sc_q, sc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] sh_value_q, sh_value_d;
   logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic [DIGITS-1:0]   anode_q, anode_d;
   logic [7:0]          cathode_q, cathode_d;
   logic                frame_done_q, frame_done_d;
   logic                slot_wrap, frame_end, in_gap, lit;
   logic [3:0]          nib;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   lz_sup;

`ifdef SEG7_LZ_BLANK_EN
   logic [DIGITS:0] zero_up;

   // A digit is suppressed when it and every digit to its left are zero; digit 0 always shows.
   always_comb begin
      zero_up = '0;
      zero_up[DIGITS] = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_up[i] = zero_up[i+1] && (sh_value_q[4*i +: 4] == 4'h0);
      end
      lz_sup    = zero_up[DIGITS-1:0];
      lz_sup[0] = 1'b0;
   end
`else
   assign lz_sup = '0;
`endif

   always_comb begin
      slot_wrap  = en && (sc_q == SC_W'(REFRESH_DIV - 1));
      frame_end  = (idx_q == IDX_W'(DIGITS - 1));
      sc_d       = sc_q;
      idx_d      = idx_q;
      sh_value_d = sh_value_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      if (en) begin
         if (slot_wrap) begin
            sc_d  = '0;
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
         end else begin
            sc_d = sc_q + SC_W'(1);
         end
      end
      // Inputs are only sampled at the frame boundary so a frame never mixes two values.
      if (slot_wrap && frame_end) begin
         sh_value_d = value;
         sh_dp_d    = dp_in;
         sh_blank_d = blank;
      end
      frame_done_d = slot_wrap && frame_end;

      nib    = sh_value_q[{idx_q, 2'b00} +: 4];
      in_gap = int'(sc_q) < BLANK_CYC;
      seg    = hex_seg(nib);
      lit    = 1'b1;
      if (lz_sup[idx_q]) begin
         seg = 7'h7F;
         lit = sh_dp_q[idx_q];
      end
      anode_d   = '1;
      cathode_d = 8'hFF;
      if (en && !in_gap && !sh_blank_q[idx_q] && lit) begin
         anode_d[idx_q] = 1'b0;
         cathode_d      = {~sh_dp_q[idx_q], seg};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sc_q         <= '0;
         idx_q        <= '0;
         sh_value_q   <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '0;
         anode_q      <= '1;
         cathode_q    <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         sc_q         <= sc_d;
         idx_q        <= idx_d;
         sh_value_q   <= sh_value_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         anode_q      <= anode_d;
         cathode_q    <= cathode_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign anode      = anode_q;
   assign cathode    = cathode_q;
   assign digit_idx  = idx_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_driver;

   localparam int DIGITS      = 4;
   localparam int REFRESH_DIV = 8;
   localparam int BLANK_CYC   = 2;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b1;
   logic        en      = 1'b0;
   logic [15:0] value   = '0;
   logic [3:0]  dp_in   = '0;
   logic [3:0]  blank   = '0;
   logic [3:0]  anode;
   logic [7:0]  cathode;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .DIGITS     (DIGITS),
      .REFRESH_DIV(REFRESH_DIV),
      .BLANK_CYC  (BLANK_CYC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .value     (value),
      .dp_in     (dp_in),
      .blank     (blank),
      .anode     (anode),
      .cathode   (cathode),
      .digit_idx (digit_idx),
      .frame_done(frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output cycles s_lo..s_hi of a slot; the first BLANK_CYC cycles are dark.
   task automatic check_cycles(input int slot, input int s_lo, input int s_hi,
                               input logic [3:0] an, input logic [7:0] cat);
      for (int s = s_lo; s <= s_hi; s++) begin
         tick();
         if (s < BLANK_CYC) begin
            chk($sformatf("anode_gap_d%0d_s%0d", slot, s), 32'(anode), 32'(4'hF));
            chk($sformatf("cathode_gap_d%0d_s%0d", slot, s), 32'(cathode), 32'(8'hFF));
         end else begin
            chk($sformatf("anode_d%0d_s%0d", slot, s), 32'(anode), 32'(an));
            chk($sformatf("cathode_d%0d_s%0d", slot, s), 32'(cathode), 32'(cat));
         end
         chk($sformatf("frame_done_d%0d_s%0d", slot, s), 32'(frame_done), 32'(slot == 3 && s == 7));
         chk($sformatf("digit_idx_d%0d_s%0d", slot, s), 32'(digit_idx),
             32'((s == 7) ? (slot + 1) % 4 : slot));
      end
   endtask

   task automatic check_slot(input int slot, input logic [3:0] an, input logic [7:0] cat);
      check_cycles(slot, 0, 7, an, cat);
   endtask

   // First frame after reset always shows the all-zero shadow.
   task automatic check_zero_frame();
      check_slot(0, 4'hE, 8'h81);
`ifdef SEG7_LZ_BLANK_EN
      check_slot(1, 4'hF, 8'hFF);
      check_slot(2, 4'hF, 8'hFF);
      check_slot(3, 4'hF, 8'hFF);
`else
      check_slot(1, 4'hD, 8'h81);
      check_slot(2, 4'hB, 8'h81);
      check_slot(3, 4'h7, 8'h81);
`endif
   endtask

   initial begin
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_anode", 32'(anode), 32'(4'hF));
      chk("rst_cathode", 32'(cathode), 32'(8'hFF));
      chk("rst_digit_idx", 32'(digit_idx), 32'(2'd0));
      chk("rst_frame_done", 32'(frame_done), 32'(1'b0));

      en    = 1'b1;
      value = 16'h1234;
      @(negedge clk);
      reset_n = 1'b1;
      check_zero_frame();

      // 1234, with a mid-frame change that must not show until the next frame
      check_slot(0, 4'hE, 8'hCC);
      check_slot(1, 4'hD, 8'h86);
      value = 16'hABCD;
      check_slot(2, 4'hB, 8'h92);
      check_slot(3, 4'h7, 8'hCF);

      check_slot(0, 4'hE, 8'hC2);
      check_slot(1, 4'hD, 8'hB1);
      value = 16'h1234;
      blank = 4'b0100;
      dp_in = 4'b0001;
      check_slot(2, 4'hB, 8'hE0);
      check_slot(3, 4'h7, 8'h88);

      check_slot(0, 4'hE, 8'h4C);
      check_slot(1, 4'hD, 8'h86);
      check_slot(2, 4'hF, 8'hFF);
      check_slot(3, 4'h7, 8'hCF);

      // Pause mid-slot of digit 1
      check_slot(0, 4'hE, 8'h4C);
      check_cycles(1, 0, 3, 4'hD, 8'h86);
      en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("hold_anode_%0d", k), 32'(anode), 32'(4'hF));
         chk($sformatf("hold_cathode_%0d", k), 32'(cathode), 32'(8'hFF));
         chk($sformatf("hold_digit_idx_%0d", k), 32'(digit_idx), 32'(2'd1));
         chk($sformatf("hold_frame_done_%0d", k), 32'(frame_done), 32'(1'b0));
      end
      en    = 1'b1;
      blank = 4'b0000;
      dp_in = 4'b0000;
      check_cycles(1, 4, 7, 4'hD, 8'h86);
      check_slot(2, 4'hF, 8'hFF);
      check_slot(3, 4'h7, 8'hCF);

      // Async reset mid-slot of digit 2
      check_slot(0, 4'hE, 8'hCC);
      check_slot(1, 4'hD, 8'h86);
      check_cycles(2, 0, 3, 4'hB, 8'h92);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_anode", 32'(anode), 32'(4'hF));
      chk("async_cathode", 32'(cathode), 32'(8'hFF));
      chk("async_digit_idx", 32'(digit_idx), 32'(2'd0));
      chk("async_frame_done", 32'(frame_done), 32'(1'b0));

      value = 16'h0030;
      tick();
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      check_zero_frame();
      check_slot(0, 4'hE, 8'h81);
      check_slot(1, 4'hD, 8'h86);
`ifdef SEG7_LZ_BLANK_EN
      check_slot(2, 4'hF, 8'hFF);
      check_slot(3, 4'hF, 8'hFF);
`else
      check_slot(2, 4'hB, 8'h81);
      check_slot(3, 4'h7, 8'h81);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
